uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 521, clocks per bit period; legal values 4 or more.
REQ-002 SHALL have parameter DATA_BITS, default 8, payload bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port rx_in, input, 1 bit: asynchronous serial line; idles high.
REQ-008 SHALL have port rx_data, output, DATA_BITS bits: received payload, LSB first on line.
REQ-009 SHALL have port rx_valid, output, 1 bit: holding register contains an undelivered frame.
REQ-010 SHALL have port rx_ready, input, 1 bit: consumer accepts; transfer occurs when rx_valid and rx_ready are both 1.
REQ-011 SHALL have port parity_err, output, 1 bit: parity mismatch for the frame in rx_data.
REQ-012 SHALL have port frame_err, output, 1 bit: a stop bit sampled 0 for the frame in rx_data.
REQ-013 SHALL have port overrun, output, 1 bit: at least one frame was dropped since the last transfer.
REQ-014 SHALL have port busy, output, 1 bit: 1 whenever the FSM is not in IDLE.

Function
REQ-015 SHALL pass rx_in through a 2-flop synchronizer (reset value 1); all sampling uses the synchronized bit.
REQ-016 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP with bit counter clk_cnt 0..CLKS_PER_BIT-1.
REQ-017 IDLE SHALL arm only after the synced line has been sampled 1; when armed and the line reads 0, go to START with clk_cnt=0.
REQ-018 START SHALL sample at clk_cnt = CLKS_PER_BIT/2 - 1 (integer division): 0 -> DATA with clk_cnt=0; 1 -> glitch, return to IDLE, no output.
REQ-019 DATA SHALL sample each CLKS_PER_BIT cycles after the mid-start point and shift LSB first; after DATA_BITS samples go to PARITY if PARITY!=0, else STOP.
REQ-020 PARITY SHALL sample one bit; parity_err = 1 when the XOR of data bits plus the parity bit is 1 (even) or 0 (odd); parity_err is always 0 for PARITY=0.
REQ-021 STOP SHALL sample STOP_BITS bits; any 0 sets frame_err; after the mid-point sample of the last stop bit, go to IDLE on the next cycle.
REQ-022 After a frame_err, IDLE SHALL stay disarmed until the line reads 1, so a break (line held low) yields exactly one frame.
REQ-023 Completion SHALL load rx_data, parity_err and frame_err into the holding register and raise rx_valid on the clock after the last stop sample.
REQ-024 rx_valid and the holding register SHALL remain stable until transfer; on transfer rx_valid drops on the next edge unless a new completion loads in the same cycle.
REQ-025 Completion with rx_valid=1 and no transfer in that cycle SHALL discard the new frame and set overrun=1; overrun is sticky and clears on the edge following the next transfer.
REQ-026 Completion coinciding with a transfer SHALL load the new frame, keep rx_valid=1 and leave overrun unchanged.
REQ-027 Frames with parity_err or frame_err SHALL still be delivered through the handshake.

Reset
REQ-028 rst=1 SHALL immediately force the FSM to IDLE (disarmed), clk_cnt=0, synchronizer=1, rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0, including mid-frame.
REQ-029 After rst is released, the next frame SHALL be received normally once the line has read 1.

Verification (CLKS_PER_BIT=16, rx_ready=1 unless stated)
REQ-030 8N1, send 0xE3 -> rx_valid pulses once, rx_data=0xE3, parity_err=0, frame_err=0, busy low after the stop bit.
REQ-031 PARITY=1, DATA_BITS=8, send 0xA5 with parity bit 1 -> rx_data=0xA5, parity_err=1; repeat with PARITY=2 and parity bit 1 -> parity_err=0.
REQ-032 Line low for 20 bit times, then high -> exactly one frame, rx_data=0x00, frame_err=1; no further rx_valid until a new start bit after the line returns high.
REQ-033 Low glitch of 4 clocks on an idle line -> no rx_valid; busy returns to 0 by mid-start.
REQ-034 rx_ready=0, back-to-back 0x11 then 0x22 -> rx_data=0x11, overrun=1; raise rx_ready -> one transfer of 0x11, overrun=0 next cycle.
REQ-035 rst pulsed during data bit 3 -> all outputs 0 immediately; next frame 0x5A -> rx_data=0x5A, no errors.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with a one-deep holding register.
// Handshake: a frame moves to the consumer on any rising edge where rx_valid
// and rx_ready are both 1. rx_valid and the held frame stay stable until then.
// state_dbg exposes the receive FSM state for observation.
module uart_rx_cfg #(
   parameter int CLKS_PER_BIT = 521,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy,
   output logic [2:0]           state_dbg
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [3:0]       BIT_LAST = 4'(DATA_BITS - 1);
   localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic                 rx_meta_q, rx_sync_q;
   logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
   logic [3:0]           bit_idx_q, bit_idx_d;
   logic                 stop_idx_q, stop_idx_d;
   logic                 armed_q, armed_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_bit_q, par_bit_d;
   logic                 ferr_acc_q, ferr_acc_d;
   logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
   logic                 hold_perr_q, hold_perr_d;
   logic                 hold_ferr_q, hold_ferr_d;
   logic                 valid_q, valid_d;
   logic                 overrun_q, overrun_d;

   logic done;
   logic xfer;
   logic frame_perr;
   logic frame_ferr;
   logic par_xor;

   // Frame status evaluated at the last stop sample (shift and parity bit are final by then).
   always_comb begin
      par_xor    = ^{shift_q, par_bit_q};
      frame_perr = 1'b0;
      if (PARITY == 1) frame_perr = par_xor;
      else if (PARITY == 2) frame_perr = ~par_xor;
      frame_ferr = ferr_acc_q | ~rx_sync_q;
   end

   // Receive FSM next state plus holding register / overrun update.
   always_comb begin
      state_d     = state_q;
      clk_cnt_d   = clk_cnt_q;
      bit_idx_d   = bit_idx_q;
      stop_idx_d  = stop_idx_q;
      armed_d     = armed_q;
      shift_d     = shift_q;
      par_bit_d   = par_bit_q;
      ferr_acc_d  = ferr_acc_q;
      hold_data_d = hold_data_q;
      hold_perr_d = hold_perr_q;
      hold_ferr_d = hold_ferr_q;
      valid_d     = valid_q;
      overrun_d   = overrun_q;
      done        = 1'b0;
      xfer        = valid_q & rx_ready;

      case (state_q)
         S_IDLE: begin
            clk_cnt_d = '0;
            // Arming requires a 1 first, so a held-low break cannot retrigger.
            if (rx_sync_q) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               armed_d = 1'b0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (clk_cnt_q == CNT_MID) begin
               clk_cnt_d = '0;
               if (!rx_sync_q) begin
                  state_d    = S_DATA;
                  bit_idx_d  = '0;
                  ferr_acc_d = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (clk_cnt_q == CNT_LAST) begin
               clk_cnt_d = '0;
               shift_d   = {rx_sync_q, shift_q[DATA_BITS-1:1]};
               if (bit_idx_q == BIT_LAST) begin
                  state_d    = (PARITY != 0) ? S_PARITY : S_STOP;
                  stop_idx_d = 1'b0;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         S_PARITY: begin
            if (clk_cnt_q == CNT_LAST) begin
               clk_cnt_d  = '0;
               par_bit_d  = rx_sync_q;
               state_d    = S_STOP;
               stop_idx_d = 1'b0;
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (clk_cnt_q == CNT_LAST) begin
               clk_cnt_d = '0;
               if (!rx_sync_q) ferr_acc_d = 1'b1;
               if (stop_idx_q == STOP_LAST) begin
                  state_d = S_IDLE;
                  done    = 1'b1;
               end else begin
                  stop_idx_d = 1'b1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d   = S_IDLE;
            clk_cnt_d = '0;
         end
      endcase

      // A completing frame is kept only if the holding register is free or draining now.
      if (done) begin
         if (!valid_q || xfer) begin
            hold_data_d = shift_q;
            hold_perr_d = frame_perr;
            hold_ferr_d = frame_ferr;
            valid_d     = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (xfer) begin
         valid_d   = 1'b0;
         overrun_d = 1'b0;
      end
   end

   // State registers, synchronizer idles high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q   <= 1'b1;
         rx_sync_q   <= 1'b1;
         state_q     <= S_IDLE;
         clk_cnt_q   <= '0;
         bit_idx_q   <= '0;
         stop_idx_q  <= 1'b0;
         armed_q     <= 1'b0;
         shift_q     <= '0;
         par_bit_q   <= 1'b0;
         ferr_acc_q  <= 1'b0;
         hold_data_q <= '0;
         hold_perr_q <= 1'b0;
         hold_ferr_q <= 1'b0;
         valid_q     <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         rx_meta_q   <= rx_in;
         rx_sync_q   <= rx_meta_q;
         state_q     <= state_d;
         clk_cnt_q   <= clk_cnt_d;
         bit_idx_q   <= bit_idx_d;
         stop_idx_q  <= stop_idx_d;
         armed_q     <= armed_d;
         shift_q     <= shift_d;
         par_bit_q   <= par_bit_d;
         ferr_acc_q  <= ferr_acc_d;
         hold_data_q <= hold_data_d;
         hold_perr_q <= hold_perr_d;
         hold_ferr_q <= hold_ferr_d;
         valid_q     <= valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rx_data    = hold_data_q;
   assign rx_valid   = valid_q;
   assign parity_err = hold_perr_q;
   assign frame_err  = hold_ferr_q;
   assign overrun    = overrun_q;
   assign busy       = (state_q != S_IDLE);
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg: three instances (no parity, even, odd) at 16 clocks per bit.
module tb_uart_rx_cfg;

   localparam int CPB = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic rx_n = 1'b1, rx_e = 1'b1, rx_o = 1'b1;
   logic rx_ready = 1'b1;

   logic [7:0] data_n, data_e, data_o;
   logic       valid_n, valid_e, valid_o;
   logic       perr_n, perr_e, perr_o;
   logic       ferr_n, ferr_e, ferr_o;
   logic       ovr_n, ovr_e, ovr_o;
   logic       busy_n, busy_e, busy_o;
   logic [2:0] st_n, st_e, st_o;

   uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n (
      .clk(clk), .rst(rst), .rx_in(rx_n), .rx_data(data_n), .rx_valid(valid_n),
      .rx_ready(rx_ready), .parity_err(perr_n), .frame_err(ferr_n), .overrun(ovr_n),
      .busy(busy_n), .state_dbg(st_n));

   uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_e (
      .clk(clk), .rst(rst), .rx_in(rx_e), .rx_data(data_e), .rx_valid(valid_e),
      .rx_ready(rx_ready), .parity_err(perr_e), .frame_err(ferr_e), .overrun(ovr_e),
      .busy(busy_e), .state_dbg(st_e));

   uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_o (
      .clk(clk), .rst(rst), .rx_in(rx_o), .rx_data(data_o), .rx_valid(valid_o),
      .rx_ready(rx_ready), .parity_err(perr_o), .frame_err(ferr_o), .overrun(ovr_o),
      .busy(busy_o), .state_dbg(st_o));

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [9:0] exp_q[$];
   logic [9:0] got_n[$], got_e[$], got_o[$];

   // Record every transfer ({frame_err, parity_err, data}) away from the active edge.
   always @(negedge clk) begin
      if (!rst && rx_ready) begin
         if (valid_n) got_n.push_back({ferr_n, perr_n, data_n});
         if (valid_e) got_e.push_back({ferr_e, perr_e, data_e});
         if (valid_o) got_o.push_back({ferr_o, perr_o, data_o});
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_line(input int sel, input logic v);
      case (sel)
         0: rx_n = v;
         1: rx_e = v;
         default: rx_o = v;
      endcase
   endtask

   task automatic drive_bit(input int sel, input logic v);
      set_line(sel, v);
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int sel, input logic [7:0] d, input bit has_par,
                             input bit pbit, input bit stopv);
      @(posedge clk); #1;
      drive_bit(sel, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
      if (has_par) drive_bit(sel, pbit);
      drive_bit(sel, stopv);
      drive_bit(sel, 1'b1);
      drive_bit(sel, 1'b1);
   endtask

   task automatic wait_result(input int sel, output logic [9:0] got, output bit ok);
      ok  = 1'b0;
      got = '0;
      for (int i = 0; i < 40 * CPB && !ok; i++) begin
         @(negedge clk);
         case (sel)
            0: if (got_n.size() > 0) begin got = got_n.pop_front(); ok = 1'b1; end
            1: if (got_e.size() > 0) begin got = got_e.pop_front(); ok = 1'b1; end
            default: if (got_o.size() > 0) begin got = got_o.pop_front(); ok = 1'b1; end
         endcase
      end
   endtask

   function automatic logic busy_of(input int sel);
      case (sel)
         0: return busy_n;
         1: return busy_e;
         default: return busy_o;
      endcase
   endfunction

   // ---------------- vectors ----------------
   typedef struct {
      int         sel;
      logic [7:0] data;
      bit         has_par;
      bit         pbit;
      bit         stopv;
      logic [7:0] exp_data;
      bit         exp_perr;
      bit         exp_ferr;
   } vec_t;

   vec_t vecs[9];

   // Safety net in case the sequence never reaches the summary.
   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [9:0] got;
      logic [9:0] exp;
      bit         ok;

      vecs[0] = '{0, 8'hE3, 1'b0, 1'b0, 1'b1, 8'hE3, 1'b0, 1'b0};
      vecs[1] = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
      vecs[2] = '{0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
      vecs[3] = '{0, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1};
      vecs[4] = '{1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
      vecs[5] = '{1, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
      vecs[6] = '{2, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
      vecs[7] = '{2, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
      vecs[8] = '{1, 8'h01, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};

      // Reset state
      repeat (4) @(posedge clk);
      #1;
      check("reset_valid", valid_n, 0);
      check("reset_data", data_n, 0);
      check("reset_overrun", ovr_n, 0);
      check("reset_busy", busy_n, 0);
      rst = 1'b0;
      repeat (4) @(posedge clk);

      // Table-driven frames
      foreach (vecs[k]) begin
         exp_q.push_back({vecs[k].exp_ferr, vecs[k].exp_perr, vecs[k].exp_data});
         send_frame(vecs[k].sel, vecs[k].data, vecs[k].has_par, vecs[k].pbit, vecs[k].stopv);
         wait_result(vecs[k].sel, got, ok);
         exp = exp_q.pop_front();
         check($sformatf("vec%0d_timeout", k), ok, 1);
         check($sformatf("vec%0d_frame", k), got, exp);
         check($sformatf("vec%0d_busy_idle", k), busy_of(vecs[k].sel), 0);
      end

      // Break: line low for 20 bit times gives exactly one frame
      @(posedge clk); #1;
      rx_n = 1'b0;
      repeat (20 * CPB) @(posedge clk);
      #1;
      rx_n = 1'b1;
      wait_result(0, got, ok);
      check("break_timeout", ok, 1);
      check("break_frame", got, {1'b1, 1'b0, 8'h00});
      repeat (3 * CPB) @(posedge clk);
      check("break_single", got_n.size(), 0);
      send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
      wait_result(0, got, ok);
      check("after_break_frame", got, {2'b00, 8'h3C});

      // Short low glitch is rejected at mid-start
      @(posedge clk); #1;
      rx_n = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rx_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("glitch_busy_seen", busy_n, 1);
      repeat (10) @(posedge clk);
      #1;
      check("glitch_busy_clear", busy_n, 0);
      repeat (3 * CPB) @(posedge clk);
      check("glitch_no_frame", got_n.size(), 0);

      // Overrun: two frames with consumer stalled
      rx_ready = 1'b0;
      send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
      send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
      check("ovr_valid", valid_n, 1);
      check("ovr_data", data_n, 8'h11);
      check("ovr_flag", ovr_n, 1);
      rx_ready = 1'b1;
      @(posedge clk); #1;
      check("ovr_valid_drop", valid_n, 0);
      check("ovr_clear", ovr_n, 0);
      check("ovr_one_transfer", got_n.size(), 1);
      if (got_n.size() > 0) begin
         got = got_n.pop_front();
         check("ovr_xfer_data", got, {2'b00, 8'h11});
      end

      // Reset mid-frame with held frame and overrun pending
      rx_ready = 1'b0;
      send_frame(0, 8'h81, 1'b0, 1'b0, 1'b0);
      send_frame(0, 8'h42, 1'b0, 1'b0, 1'b1);
      check("pre_rst_ferr", ferr_n, 1);
      check("pre_rst_overrun", ovr_n, 1);
      @(posedge clk); #1;
      drive_bit(0, 1'b0);
      drive_bit(0, 1'b0);
      drive_bit(0, 1'b1);
      drive_bit(0, 1'b0);
      rx_n = 1'b1;
      repeat (CPB / 2) @(posedge clk);
      #1;
      check("pre_rst_busy", busy_n, 1);
      rst = 1'b1;
      #1;
      check("rst_valid", valid_n, 0);
      check("rst_data", data_n, 0);
      check("rst_perr", perr_n, 0);
      check("rst_ferr", ferr_n, 0);
      check("rst_overrun", ovr_n, 0);
      check("rst_busy", busy_n, 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      rx_ready = 1'b1;
      repeat (2 * CPB) @(posedge clk);
      send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
      wait_result(0, got, ok);
      check("post_rst_timeout", ok, 1);
      check("post_rst_frame", got, {2'b00, 8'h5A});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
